// File: rtl/zeroheti_pkg.sv
// Shared definitions for the zeroheti APB timer: register offsets,
// control register layout, prescaler FSM states and a byte-strobe helper.
package zeroheti_pkg;

  localparam logic [4:0] TimerCtrlOffs   = 5'h00;
  localparam logic [4:0] TimerPrescOffs  = 5'h04;
  localparam logic [4:0] TimerCountOffs  = 5'h08;
  localparam logic [4:0] TimerCmpOffs    = 5'h0C;
  localparam logic [4:0] TimerStatusOffs = 5'h10;

  localparam int unsigned TimerRegCount = 5;

  // CTRL[2:0] maps directly onto this struct: bit 2 IE, bit 1 AUTORELOAD, bit 0 EN
  typedef struct packed {
    logic ie;
    logic autoreload;
    logic en;
  } timer_ctrl_t;

  typedef enum logic {
    PscIdle = 1'b0,
    PscRun  = 1'b1
  } psc_state_e;

  // Replace the bytes of oldVal selected by strb with the matching bytes of newVal
  function automatic logic [31:0] applyStrb(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  strb);
    logic [31:0] res;
    res = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = newVal[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/zeroheti_timer_core.sv
// Timer datapath: prescaler FSM, 32-bit counter, compare, MATCH flag and
// registered interrupt. Register values and write pulses come from the APB side.
module zeroheti_timer_core
  import zeroheti_pkg::*;
#(
  parameter int unsigned PrescWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  timer_ctrl_t           ctrl_i,
  input  logic [PrescWidth-1:0] presc_i,
  input  logic [31:0]           cmp_i,
  input  logic                  countWe_i,
  input  logic [31:0]           countWdata_i,
  input  logic                  matchClr_i,
  output logic [31:0]           count_o,
  output logic                  match_o,
  output logic                  irq_o
);

  psc_state_e            state_q;
  logic [PrescWidth-1:0] psc_q;
  logic [31:0]           count_q, count_d;
  logic                  match_q, match_d;
  logic                  irq_q, irq_d;
  logic                  tick;
  logic                  matchHit;

  // Tick fires when the running prescaler reaches PRESC; a prescaler already
  // above a freshly lowered PRESC simply wraps at its own width first
  always_comb begin
    tick     = ctrl_i.en && (psc_q == presc_i);
    matchHit = tick && (count_q == cmp_i);
  end

  // Prescaler FSM: counting while EN is set, cleared and parked in IDLE otherwise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PscIdle;
      psc_q   <= '0;
    end else begin
      case (state_q)
        PscIdle: begin
          if (ctrl_i.en) begin
            state_q <= PscRun;
            psc_q   <= tick ? '0 : psc_q + PrescWidth'(1);
          end else begin
            psc_q <= '0;
          end
        end
        PscRun: begin
          if (!ctrl_i.en) begin
            state_q <= PscIdle;
            psc_q   <= '0;
          end else begin
            psc_q <= tick ? '0 : psc_q + PrescWidth'(1);
          end
        end
      endcase
    end
  end

  // Next-state for counter, MATCH flag and interrupt; software COUNT writes
  // beat the tick increment and a new match beats a W1C
  always_comb begin
    count_d = count_q;
    if (countWe_i) begin
      count_d = countWdata_i;
    end else if (tick) begin
      count_d = (matchHit && ctrl_i.autoreload) ? 32'd0 : count_q + 32'd1;
    end

    match_d = match_q;
    if (matchClr_i) begin
      match_d = 1'b0;
    end
    if (matchHit) begin
      match_d = 1'b1;
    end

    irq_d = match_q & ctrl_i.ie;
  end

  // Counter, MATCH and interrupt state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      match_q <= match_d;
      irq_q   <= irq_d;
    end
  end

  assign count_o = count_q;
  assign match_o = match_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/zeroheti_apb_timer.sv
// Zero-wait-state APB completer wrapping the timer core: address decode,
// error response, byte-strobed register file and combinational read mux.
module zeroheti_apb_timer
  import zeroheti_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned PrescWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [31:0]          pwdata_i,
  input  logic [3:0]           pstrb_i,
  output logic [31:0]          prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 irq_o
);

  localparam logic [2:0] LastRegIdx = 3'(TimerRegCount - 1);

  timer_ctrl_t           ctrl_q, ctrl_d;
  logic [PrescWidth-1:0] presc_q, presc_d;
  logic [31:0]           cmp_q, cmp_d;
  logic [31:0]           countVal;
  logic [31:0]           countWdata;
  logic                  countWe;
  logic                  matchClr;
  logic                  matchVal;
  logic                  access;
  logic                  addrErr;
  logic                  wrEn;
  logic [4:0]            regOffs;
  logic [31:0]           rdata;
  logic                  unused_addr;

  assign access      = psel_i & penable_i;
  assign regOffs     = {paddr_i[4:2], 2'b00};
  assign addrErr     = (paddr_i[1:0] != 2'b00) || (paddr_i[4:2] > LastRegIdx);
  assign wrEn        = access & pwrite_i & ~addrErr;
  assign pslverr_o   = access & addrErr;
  assign pready_o    = 1'b1;
  assign countWdata  = applyStrb(countVal, pwdata_i, pstrb_i);
  assign unused_addr = ^paddr_i[AddrWidth-1:5];

  // Register write decode; faulting accesses never reach here because wrEn excludes them
  always_comb begin
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    cmp_d    = cmp_q;
    countWe  = 1'b0;
    matchClr = 1'b0;
    if (wrEn) begin
      case (regOffs)
        TimerCtrlOffs: begin
          if (pstrb_i[0]) begin
            ctrl_d = timer_ctrl_t'(pwdata_i[2:0]);
          end
        end
        TimerPrescOffs: begin
          for (int b = 0; b < PrescWidth; b++) begin
            if (pstrb_i[b/8]) begin
              presc_d[b] = pwdata_i[b];
            end
          end
        end
        TimerCountOffs:  countWe  = 1'b1;
        TimerCmpOffs:    cmp_d    = applyStrb(cmp_q, pwdata_i, pstrb_i);
        TimerStatusOffs: matchClr = pstrb_i[0] & pwdata_i[0];
        default: ;
      endcase
    end
  end

  // Software-visible configuration registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      cmp_q   <= cmp_d;
    end
  end

  // Read mux, driven only during a valid access phase and zero otherwise
  always_comb begin
    rdata = '0;
    if (access && !addrErr) begin
      case (regOffs)
        TimerCtrlOffs:   rdata[2:0]            = ctrl_q;
        TimerPrescOffs:  rdata[PrescWidth-1:0] = presc_q;
        TimerCountOffs:  rdata                 = countVal;
        TimerCmpOffs:    rdata                 = cmp_q;
        TimerStatusOffs: rdata[0]              = matchVal;
        default: ;
      endcase
    end
  end

  assign prdata_o = rdata;

  zeroheti_timer_core #(
    .PrescWidth(PrescWidth)
  ) u_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ctrl_i      (ctrl_q),
    .presc_i     (presc_q),
    .cmp_i       (cmp_q),
    .countWe_i   (countWe),
    .countWdata_i(countWdata),
    .matchClr_i  (matchClr),
    .count_o     (countVal),
    .match_o     (matchVal),
    .irq_o       (irq_o)
  );

endmodule

// File: tb/tb_zeroheti_apb_timer.sv
// Self-checking bench for zeroheti_apb_timer: a register/error vector table
// followed by hand-timed sequences for prescaling, wrap, collisions and reset.
module tb_zeroheti_apb_timer;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] expRdata;
    logic        expErr;
  } apbVec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        checkData;
    string       name;
  } sbEntry_t;

  logic        clock;
  logic        reset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  sbEntry_t sbQueue[$];
  apbVec_t  vecs[26];
  int       errors = 0;
  int       checks = 0;

  zeroheti_apb_timer dut (
    .clk_i    (clock),
    .rst_i    (reset),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .paddr_i  (paddr),
    .pwdata_i (pwdata),
    .pstrb_i  (pstrb),
    .prdata_o (prdata),
    .pready_o (pready),
    .pslverr_o(pslverr),
    .irq_o    (irq)
  );

  // Free-running 100 MHz clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so a stuck run still terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic apbVec_t mkVec(input logic w, input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] s, input logic [31:0] er, input logic ee);
    apbVec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.strb = s; v.expRdata = er; v.expErr = ee;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    sbEntry_t e;
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: no expected entry for access phase");
      return;
    end
    e = sbQueue.pop_front();
    checkValue({e.name, ".pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
    checkValue({e.name, ".pready"}, {31'd0, pready}, 32'd1);
    if (e.checkData) begin
      checkValue({e.name, ".prdata"}, prdata, e.rdata);
    end
  endtask

  task automatic applyStimulus(input apbVec_t v, input string name);
    sbEntry_t e;
    e.rdata = v.expRdata; e.err = v.expErr; e.checkData = !v.write; e.name = name;
    sbQueue.push_back(e);
    @(posedge clock); #1;
    psel = 1'b1; penable = 1'b0; pwrite = v.write;
    paddr = v.addr; pwdata = v.wdata; pstrb = v.strb;
    @(posedge clock); #1;
    penable = 1'b1;
    @(negedge clock);
    checkOutput();
    @(posedge clock); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apbWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string name);
    applyStimulus(mkVec(1'b1, a, d, s, 32'd0, 1'b0), name);
  endtask

  task automatic apbRead(input logic [31:0] a, input logic [31:0] exp, input string name);
    applyStimulus(mkVec(1'b0, a, 32'd0, 4'h0, exp, 1'b0), name);
  endtask

  initial begin
    bit gotIrq;
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;

    $display("[TB] reset and idle outputs");
    repeat (2) @(negedge clock);
    checkValue("rst.prdata", prdata, 32'd0);
    checkValue("rst.pready", {31'd0, pready}, 32'd1);
    checkValue("rst.pslverr", {31'd0, pslverr}, 32'd0);
    checkValue("rst.irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    // Reset values, error responses and byte strobes
    vecs[0]  = mkVec(0, 32'h00, 32'h0, 4'h0, 32'h0000_0000, 0);
    vecs[1]  = mkVec(0, 32'h04, 32'h0, 4'h0, 32'h0000_0000, 0);
    vecs[2]  = mkVec(0, 32'h08, 32'h0, 4'h0, 32'h0000_0000, 0);
    vecs[3]  = mkVec(0, 32'h0C, 32'h0, 4'h0, 32'hFFFF_FFFF, 0);
    vecs[4]  = mkVec(0, 32'h10, 32'h0, 4'h0, 32'h0000_0000, 0);
    vecs[5]  = mkVec(0, 32'h18, 32'h0, 4'h0, 32'h0000_0000, 1);
    vecs[6]  = mkVec(1, 32'h18, 32'hDEAD_BEEF, 4'hF, 32'h0, 1);
    vecs[7]  = mkVec(0, 32'h02, 32'h0, 4'h0, 32'h0000_0000, 1);
    vecs[8]  = mkVec(1, 32'h0E, 32'h1234_5678, 4'hF, 32'h0, 1);
    vecs[9]  = mkVec(0, 32'h0C, 32'h0, 4'h0, 32'hFFFF_FFFF, 0);
    vecs[10] = mkVec(1, 32'h0C, 32'hAABB_CCDD, 4'h2, 32'h0, 0);
    vecs[11] = mkVec(0, 32'h0C, 32'h0, 4'h0, 32'hFFFF_CCFF, 0);
    vecs[12] = mkVec(1, 32'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0, 0);
    vecs[13] = mkVec(1, 32'h04, 32'h1234_5678, 4'h1, 32'h0, 0);
    vecs[14] = mkVec(0, 32'h04, 32'h0, 4'h0, 32'h0000_0078, 0);
    vecs[15] = mkVec(1, 32'h04, 32'h0, 4'hF, 32'h0, 0);
    vecs[16] = mkVec(1, 32'h00, 32'hFFFF_FFF8, 4'hF, 32'h0, 0);
    vecs[17] = mkVec(0, 32'h00, 32'h0, 4'h0, 32'h0000_0000, 0);
    vecs[18] = mkVec(1, 32'h00, 32'h0000_0006, 4'hF, 32'h0, 0);
    vecs[19] = mkVec(0, 32'h00, 32'h0, 4'h0, 32'h0000_0006, 0);
    vecs[20] = mkVec(1, 32'h00, 32'h0, 4'hF, 32'h0, 0);
    vecs[21] = mkVec(0, 32'h14, 32'h0, 4'h0, 32'h0000_0000, 1);
    vecs[22] = mkVec(1, 32'h0A, 32'h0000_0005, 4'hF, 32'h0, 1);
    vecs[23] = mkVec(0, 32'h08, 32'h0, 4'h0, 32'h0000_0000, 0);
    vecs[24] = mkVec(1, 32'h10, 32'hFFFF_FFFE, 4'h1, 32'h0, 0);
    vecs[25] = mkVec(0, 32'h10, 32'h0, 4'h0, 32'h0000_0000, 0);

    $display("[TB] register table");
    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end
    @(negedge clock);
    checkValue("table.irq", {31'd0, irq}, 32'd0);

    // Auto-reload: tick every 4 cycles, MATCH set 24 cycles after enable
    $display("[TB] auto-reload sequence");
    apbWrite(32'h04, 32'd3, 4'hF, "ar.presc");
    apbWrite(32'h0C, 32'd5, 4'hF, "ar.cmp");
    apbWrite(32'h00, 32'h7, 4'hF, "ar.ctrl");
    repeat (25) @(negedge clock);
    checkValue("ar.irqBeforeMatch", {31'd0, irq}, 32'd0);
    @(negedge clock);
    checkValue("ar.irqAfterMatch", {31'd0, irq}, 32'd1);
    apbRead(32'h08, 32'd0, "ar.countReloaded");
    apbRead(32'h10, 32'd1, "ar.statusSet");
    apbWrite(32'h10, 32'd1, 4'h1, "ar.w1c");
    @(negedge clock);
    checkValue("ar.irqStillHigh", {31'd0, irq}, 32'd1);
    @(negedge clock);
    checkValue("ar.irqCleared", {31'd0, irq}, 32'd0);
    apbWrite(32'h00, 32'h0, 4'hF, "ar.disable");

    // Wrap-around with PRESC = 0; reads land 2, 5, 8 ... cycles after enable
    $display("[TB] wrap sequence");
    apbWrite(32'h04, 32'd0, 4'hF, "wr.presc");
    apbWrite(32'h08, 32'hFFFF_FFFE, 4'hF, "wr.count");
    apbWrite(32'h0C, 32'h10, 4'hF, "wr.cmp");
    apbWrite(32'h00, 32'h1, 4'hF, "wr.ctrl");
    apbRead(32'h08, 32'h0000_0000, "wr.countWrapped");
    apbRead(32'h08, 32'h0000_0003, "wr.countAfterWrap");
    for (int k = 0; k < 4; k++) begin
      apbRead(32'h10, 32'd0, $sformatf("wr.statusClear%0d", k));
    end
    apbRead(32'h10, 32'd1, "wr.statusMatched");
    @(negedge clock);
    checkValue("wr.irqMasked", {31'd0, irq}, 32'd0);
    apbRead(32'h08, 32'h0000_0015, "wr.countNoReload");
    apbWrite(32'h00, 32'h0, 4'hF, "wr.disable");
    apbWrite(32'h10, 32'h1, 4'h1, "wr.w1c");

    // Collisions: COUNT write on a tick, W1C on a match cycle
    $display("[TB] collision sequence");
    apbWrite(32'h04, 32'd3, 4'hF, "co.presc");
    apbWrite(32'h0C, 32'd0, 4'hF, "co.cmp");
    apbWrite(32'h08, 32'd0, 4'hF, "co.count");
    apbWrite(32'h00, 32'h1, 4'hF, "co.ctrl");
    @(posedge clock);
    apbWrite(32'h08, 32'h100, 4'hF, "co.countOnTick");
    apbRead(32'h08, 32'h100, "co.countWriteWins");
    apbRead(32'h10, 32'd1, "co.matchOnOldCount");
    apbWrite(32'h00, 32'h0, 4'hF, "co.disable");
    apbWrite(32'h10, 32'h1, 4'h1, "co.clear");
    apbRead(32'h10, 32'd0, "co.statusCleared");
    apbWrite(32'h08, 32'd0, 4'hF, "co.countZero");
    apbWrite(32'h00, 32'h1, 4'hF, "co.reenable");
    @(posedge clock);
    apbWrite(32'h10, 32'h1, 4'h1, "co.w1cOnMatch");
    apbRead(32'h10, 32'd1, "co.setWins");
    apbWrite(32'h00, 32'h0, 4'hF, "co.disable2");

    // Asynchronous reset while the interrupt is active
    $display("[TB] reset mid-operation");
    apbWrite(32'h04, 32'd0, 4'hF, "rs.presc");
    apbWrite(32'h0C, 32'd2, 4'hF, "rs.cmp");
    apbWrite(32'h08, 32'd0, 4'hF, "rs.count");
    apbWrite(32'h10, 32'h1, 4'h1, "rs.w1c");
    apbWrite(32'h00, 32'h7, 4'hF, "rs.ctrl");
    gotIrq = 1'b0;
    for (int c = 0; c < 40 && !gotIrq; c++) begin
      @(negedge clock);
      gotIrq = irq;
    end
    checkValue("rs.irqRaised", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    #1;
    checkValue("rs.irqAsync", {31'd0, irq}, 32'd0);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h08;
    #1;
    checkValue("rs.countAsync", prdata, 32'd0);
    paddr = 32'h00;
    #1;
    checkValue("rs.ctrlAsync", prdata, 32'd0);
    paddr = 32'h0C;
    #1;
    checkValue("rs.cmpAsync", prdata, 32'hFFFF_FFFF);
    pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h7; pstrb = 4'hF;
    @(posedge clock); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    apbRead(32'h00, 32'd0, "rs.writeAbandoned");
    apbRead(32'h08, 32'd0, "rs.countStill0");
    @(negedge clock);
    checkValue("rs.irqAfter", {31'd0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
